// File: rtl/uvmt_cv32e40s_pkg.sv
// Shared types and defaults for the CV32E40S formal OBI slave stub.
// Entry fields are sized for the widest supported stub geometry.
package uvmt_cv32e40s_pkg;

  localparam int OBI_DEPTH          = 4;
  localparam int OBI_LATENCY        = 1;
  localparam int OBI_MAX_DATA_WIDTH = 128;
  localparam int OBI_MAX_BE_WIDTH   = OBI_MAX_DATA_WIDTH / 8;
  localparam int OBI_IDX_WIDTH      = 16;
  localparam int OBI_AGE_WIDTH      = 8;

  typedef struct packed {
    logic                          we;
    logic [OBI_IDX_WIDTH-1:0]      idx;
    logic [OBI_MAX_BE_WIDTH-1:0]   be;
    logic [OBI_MAX_DATA_WIDTH-1:0] wdata;
    logic                          err;
    logic [OBI_AGE_WIDTH-1:0]      age;
  } obi_entry_t;

  function automatic logic [OBI_AGE_WIDTH-1:0] age_step(
    input logic [OBI_AGE_WIDTH-1:0] age,
    input logic [OBI_AGE_WIDTH-1:0] lat
  );
    return (age < lat) ? age + OBI_AGE_WIDTH'(1) : lat;
  endfunction

endpackage

// File: rtl/uvmt_cv32e40s_fv_obi_stub_fifo.sv
// In-order outstanding-transaction queue for the OBI stub.
// Every slot ages each cycle; a push overwrites its slot with age 0.
module uvmt_cv32e40s_fv_obi_stub_fifo
  import uvmt_cv32e40s_pkg::*;
#(
  parameter int DEPTH   = OBI_DEPTH,
  parameter int LATENCY = OBI_LATENCY
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  obi_entry_t             push_data,
  input  logic                   pop,
  output obi_entry_t             head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [OBI_AGE_WIDTH-1:0] AGE_MAX =
    OBI_AGE_WIDTH'(LATENCY);

  obi_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i].age <= age_step(mem[i].age, AGE_MAX);
      end
      // The fresh entry overrides the aging of its own slot.
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case (1'b1)
        push && !pop: count <= count + CNT_W'(1);
        pop && !push: count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/uvmt_cv32e40s_fv_obi_stub.sv
// CV32E40S formal OBI slave stub: in-order responder over a word store.
// Define UVMT_FV_OBI_ERR_EN to add err_inject and error responses.
module uvmt_cv32e40s_fv_obi_stub
  import uvmt_cv32e40s_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = OBI_DEPTH,
  parameter int LATENCY    = OBI_LATENCY,
  parameter int MEM_WORDS  = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    req,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic                    gnt_stall,
  input  logic                    rvalid_stall,
`ifdef UVMT_FV_OBI_ERR_EN
  input  logic                    err_inject,
`endif
  output logic                    gnt,
  output logic                    rvalid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    err,
  output logic [$clog2(DEPTH):0]  outstanding
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int OFF   = $clog2(BE_W);
  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  obi_entry_t            push_e;
  obi_entry_t            head;
  logic [CNT_W-1:0]      count;
  logic                  accept;
  logic                  head_ready;
  logic                  pop;
  logic                  inject;
  logic [IDX_W-1:0]      head_idx;
  logic [DATA_WIDTH-1:0] store [MEM_WORDS];
  logic [DATA_WIDTH-1:0] merged;
  logic                  unused_bits;

`ifdef UVMT_FV_OBI_ERR_EN
  assign inject = err_inject;
`else
  assign inject = 1'b0;
`endif

  // Grant uses the pre-pop count, so a full queue never grants.
  assign gnt    = req & ~gnt_stall & (count < CNT_W'(DEPTH));
  assign accept = req & gnt;

  always_comb begin
    push_e       = '0;
    push_e.we    = we;
    push_e.idx   = OBI_IDX_WIDTH'(addr[OFF +: IDX_W]);
    push_e.be    = OBI_MAX_BE_WIDTH'(be);
    push_e.wdata = OBI_MAX_DATA_WIDTH'(wdata);
    push_e.err   = inject;
  end

  uvmt_cv32e40s_fv_obi_stub_fifo #(
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (accept),
    .push_data (push_e),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign head_ready = (count != '0) &
                      (head.age == OBI_AGE_WIDTH'(LATENCY));
  assign pop        = head_ready & ~rvalid_stall;
  assign rvalid     = pop;
  assign head_idx   = head.idx[IDX_W-1:0];

  always_comb begin
    merged = store[head_idx];
    for (int i = 0; i < BE_W; i++) begin
      if (head.be[i]) begin
        merged[8*i +: 8] = head.wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MEM_WORDS; i++) begin
        store[i] <= '0;
      end
    end else if (pop && head.we && !head.err) begin
      store[head_idx] <= merged;
    end
  end

  assign rdata = (pop && !head.we && !head.err) ?
                 store[head_idx] : '0;

`ifdef UVMT_FV_OBI_ERR_EN
  assign err = pop & head.err;
`else
  assign err = 1'b0;
`endif

  assign outstanding = count;

  // High address bits and spare entry bits are deliberately ignored.
  assign unused_bits = ^{head, addr};

endmodule
